alu_input_sequencer: RTL and testbench

ALU_INPUT_SEQUENCER -- requirements
Module: alu_input_sequencer

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/alu_input_sequencer_if.sv | 23 ++
 rtl/key_debounce.sv | 65 ++++++
 rtl/alu_input_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_input_sequencer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: the ALU word, opcode and flag bundle, plus the
// switch-to-operand sign extension used by the input sequencer.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int SW_OPERAND_W = 17;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [3:0] aluop_t;

  typedef struct packed {
    logic negative;
    logic overflow;
    logic zero;
  } aluflags_t;

  // Board switches carry a 17-bit two's-complement operand; bit 16 is the sign.
  function automatic word_t signExtend17(input logic [SW_OPERAND_W-1:0] value);
    return {{(WORD_W - SW_OPERAND_W){value[SW_OPERAND_W-1]}}, value};
  endfunction

endpackage

// File: rtl/alu_input_sequencer_if.sv
// Operand/result bus between the input sequencer (master) and the ALU (slave).
interface alu_input_sequencer_if;
  import cpu_types_pkg::*;

  word_t  portA;
  word_t  portB;
  aluop_t opcode;
  word_t  alu_out;
  logic   alu_negative;
  logic   alu_overflow;
  logic   alu_zero;

  modport master (
    output portA, portB, opcode,
    input  alu_out, alu_negative, alu_overflow, alu_zero
  );

  modport slave (
    input  portA, portB, opcode,
    output alu_out, alu_negative, alu_overflow, alu_zero
  );

endinterface

// File: rtl/key_debounce.sv
// One push button: 2-flop synchronizer, optional debounce (ALU_SEQ_DEBOUNCE_EN),
// and a single-cycle pulse when the accepted level falls (key pressed).
module key_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst,
  input  logic keyRaw,
  output logic pressPulse
);

  logic keyMeta;
  logic keySync;
  logic accepted;
  logic acceptedPrev;

  // Released is high, so the synchronizer resets to 1 to avoid a fake press.
  always_ff @(posedge clk) begin
    if (rst) begin
      keyMeta <= 1'b1;
      keySync <= 1'b1;
    end else begin
      keyMeta <= keyRaw;
      keySync <= keyMeta;
    end
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam logic [19:0] CountLimit =
    (DEBOUNCE_CYCLES == 20'd0) ? 20'd0 : DEBOUNCE_CYCLES - 20'd1;

  logic [19:0] stableCount;

  // Count consecutive samples that disagree with the accepted level; any sample
  // that matches it again means the new level was not stable, so start over.
  always_ff @(posedge clk) begin
    if (rst) begin
      stableCount <= 20'd0;
      accepted    <= 1'b1;
    end else if (keySync == accepted) begin
      stableCount <= 20'd0;
    end else if (stableCount >= CountLimit) begin
      stableCount <= 20'd0;
      accepted    <= keySync;
    end else begin
      stableCount <= stableCount + 20'd1;
    end
  end
`else
  logic unusedDebounceCfg;
  assign unusedDebounceCfg = ^DEBOUNCE_CYCLES;
  assign accepted = keySync;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acceptedPrev <= 1'b1;
    end else begin
      acceptedPrev <= accepted;
    end
  end

  assign pressPulse = acceptedPrev & ~accepted;

endmodule

// File: rtl/alu_input_sequencer.sv
// Steps ALU operands, opcode and result capture from board switches and keys.
// Define ALU_SEQ_DEBOUNCE_EN to debounce the enter/abort keys.
module alu_input_sequencer
  import cpu_types_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [17:0]                 SW,
  input  logic [3:0]                  KEY,
  alu_input_sequencer_if.master       aluBus,
  output word_t                       result,
  output logic [2:0]                  flags,
  output logic                        result_valid,
  output logic [2:0]                  state_code
);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  state_t    state;
  logic [17:0] swMeta;
  logic [17:0] swSync;
  logic      enterPulse;
  logic      abortPulse;
  word_t     portAReg;
  word_t     portBReg;
  aluop_t    opcodeReg;
  aluflags_t aluFlags;
  logic      unusedInputs;

  assign unusedInputs = ^{KEY[3:2], swSync[17]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      swMeta <= '0;
      swSync <= '0;
    end else begin
      swMeta <= SW;
      swSync <= swMeta;
    end
  end

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uEnterKey (
    .clk        (CLK),
    .rst        (RST),
    .keyRaw     (KEY[0]),
    .pressPulse (enterPulse)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uAbortKey (
    .clk        (CLK),
    .rst        (RST),
    .keyRaw     (KEY[1]),
    .pressPulse (abortPulse)
  );

  assign aluFlags = '{negative: aluBus.alu_negative,
                      overflow: aluBus.alu_overflow,
                      zero:     aluBus.alu_zero};

  // Abort outranks enter in every state; enter has no effect while in EXEC.
  always_ff @(posedge CLK) begin
    if (RST || abortPulse) begin
      state        <= LOAD_A;
      portAReg     <= '0;
      portBReg     <= '0;
      opcodeReg    <= '0;
      result       <= '0;
      flags        <= 3'b000;
      result_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (enterPulse) begin
            portAReg <= signExtend17(swSync[16:0]);
            state    <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (enterPulse) begin
            portBReg <= signExtend17(swSync[16:0]);
            state    <= LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (enterPulse) begin
            opcodeReg <= swSync[3:0];
            state     <= EXEC;
          end
        end
        EXEC: begin
          result       <= aluBus.alu_out;
          flags        <= aluFlags;
          result_valid <= 1'b1;
          state        <= SHOW;
        end
        SHOW: begin
          if (enterPulse) begin
            result_valid <= 1'b0;
            state        <= LOAD_A;
          end
        end
        default: begin
          result_valid <= 1'b0;
          state        <= LOAD_A;
        end
      endcase
    end
  end

  assign aluBus.portA  = portAReg;
  assign aluBus.portB  = portBReg;
  assign aluBus.opcode = opcodeReg;
  assign state_code    = state;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer with DEBOUNCE_CYCLES = 4; the glitch
// expectation follows ALU_SEQ_DEBOUNCE_EN.
module tb_alu_input_sequencer;
  import cpu_types_pkg::*;

  localparam logic [31:0] ST_LOAD_A  = 32'd0;
  localparam logic [31:0] ST_LOAD_B  = 32'd1;
  localparam logic [31:0] ST_LOAD_OP = 32'd2;
  localparam logic [31:0] ST_SHOW    = 32'd4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [17:0] SW;
  logic [3:0]  KEY;
  word_t       result;
  logic [2:0]  flags;
  logic        result_valid;
  logic [2:0]  state_code;

  int vecCount  = 0;
  int missCount = 0;

  alu_input_sequencer_if aluBus ();

  alu_input_sequencer #(.DEBOUNCE_CYCLES(20'd4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .SW           (SW),
    .KEY          (KEY),
    .aluBus       (aluBus),
    .result       (result),
    .flags        (flags),
    .result_valid (result_valid),
    .state_code   (state_code)
  );

  always #5 CLK = ~CLK;

  // Inputs change, and outputs are sampled, 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [17:0] sw, input logic [3:0] key, input int cycles);
    SW  = sw;
    KEY = key;
    repeat (cycles) @(posedge CLK);
    #1;
  endtask

  task automatic pressKeys(input logic [17:0] sw, input logic [3:0] key);
    applyStimulus(sw, key, 10);
    applyStimulus(sw, 4'hF, 10);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    assert (observed === expected) else begin
      missCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    RST = 1'b1;
    aluBus.alu_out      = 32'h0;
    aluBus.alu_negative = 1'b0;
    aluBus.alu_overflow = 1'b0;
    aluBus.alu_zero     = 1'b0;
    applyStimulus(18'h0, 4'hF, 3);
    checkOutput("rst_state",  {29'd0, state_code}, ST_LOAD_A);
    checkOutput("rst_portA",  aluBus.portA, 32'h0);
    checkOutput("rst_portB",  aluBus.portB, 32'h0);
    checkOutput("rst_opcode", {28'd0, aluBus.opcode}, 32'h0);
    checkOutput("rst_result", result, 32'h0);
    checkOutput("rst_flags",  {29'd0, flags}, 32'h0);
    checkOutput("rst_valid",  {31'd0, result_valid}, 32'h0);
    RST = 1'b0;
    applyStimulus(18'h0, 4'hF, 5);

    // Full operand load and execute with a negative A operand.
    aluBus.alu_out      = 32'hFFFF0008;
    aluBus.alu_negative = 1'b1;
    pressKeys(18'h10005, 4'hE);
    checkOutput("a_state", {29'd0, state_code}, ST_LOAD_B);
    checkOutput("a_portA", aluBus.portA, 32'hFFFF0005);
    pressKeys(18'h00003, 4'hE);
    checkOutput("b_state", {29'd0, state_code}, ST_LOAD_OP);
    checkOutput("b_portB", aluBus.portB, 32'h00000003);
    pressKeys(18'h00002, 4'hE);
    checkOutput("show_state",  {29'd0, state_code}, ST_SHOW);
    checkOutput("show_opcode", {28'd0, aluBus.opcode}, 32'h2);
    checkOutput("show_result", result, 32'hFFFF0008);
    checkOutput("show_flags",  {29'd0, flags}, 32'h4);
    checkOutput("show_valid",  {31'd0, result_valid}, 32'h1);

    // SHOW holds its capture while the ALU and switches move.
    aluBus.alu_out      = 32'h0;
    aluBus.alu_negative = 1'b0;
    aluBus.alu_zero     = 1'b1;
    applyStimulus(18'h3FFFF, 4'hF, 5);
    checkOutput("hold_result", result, 32'hFFFF0008);
    checkOutput("hold_flags",  {29'd0, flags}, 32'h4);
    checkOutput("hold_portA",  aluBus.portA, 32'hFFFF0005);

    pressKeys(18'h3FFFF, 4'hE);
    checkOutput("ret_state", {29'd0, state_code}, ST_LOAD_A);
    checkOutput("ret_valid", {31'd0, result_valid}, 32'h0);
    checkOutput("ret_portA", aluBus.portA, 32'hFFFF0005);
    checkOutput("ret_portB", aluBus.portB, 32'h00000003);

    // A held key advances exactly once.
    applyStimulus(18'h00007, 4'hE, 100);
    checkOutput("hold100_state", {29'd0, state_code}, ST_LOAD_B);
    checkOutput("hold100_portA", aluBus.portA, 32'h00000007);
    applyStimulus(18'h00007, 4'hF, 10);
    checkOutput("release_state", {29'd0, state_code}, ST_LOAD_B);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(((i % 2) == 1) ? 18'h3FFFF : 18'h15555, 4'hF, 1);
    end
    applyStimulus(18'h3FFFF, 4'hF, 5);
    checkOutput("toggle_portA", aluBus.portA, 32'h00000007);
    checkOutput("toggle_portB", aluBus.portB, 32'h00000003);
    checkOutput("toggle_state", {29'd0, state_code}, ST_LOAD_B);

    // Bit 16 clear gives a positive operand; SW[17] is ignored.
    pressKeys(18'h2FFFF, 4'hE);
    checkOutput("pos_portB", aluBus.portB, 32'h0000FFFF);
    checkOutput("pos_state", {29'd0, state_code}, ST_LOAD_OP);

    aluBus.alu_out = 32'hCAFE0000;
    pressKeys(18'h0000A, 4'hC);
    checkOutput("both_state",  {29'd0, state_code}, ST_LOAD_A);
    checkOutput("both_portA",  aluBus.portA, 32'h0);
    checkOutput("both_portB",  aluBus.portB, 32'h0);
    checkOutput("both_opcode", {28'd0, aluBus.opcode}, 32'h0);
    checkOutput("both_result", result, 32'h0);
    checkOutput("both_flags",  {29'd0, flags}, 32'h0);
    checkOutput("both_valid",  {31'd0, result_valid}, 32'h0);

    applyStimulus(18'h1FFFF, 4'hE, 2);
    applyStimulus(18'h1FFFF, 4'hF, 15);
`ifdef ALU_SEQ_DEBOUNCE_EN
    checkOutput("glitch_state", {29'd0, state_code}, ST_LOAD_A);
    checkOutput("glitch_portA", aluBus.portA, 32'h0);
`else
    checkOutput("glitch_state", {29'd0, state_code}, ST_LOAD_B);
    checkOutput("glitch_portA", aluBus.portA, 32'hFFFFFFFF);
`endif
    pressKeys(18'h1FFFF, 4'hD);
    checkOutput("abort_state", {29'd0, state_code}, ST_LOAD_A);
    checkOutput("abort_portA", aluBus.portA, 32'h0);

    // Reset arriving while SHOW displays a result.
    aluBus.alu_out      = 32'h12345678;
    aluBus.alu_negative = 1'b0;
    aluBus.alu_overflow = 1'b0;
    aluBus.alu_zero     = 1'b1;
    pressKeys(18'h00001, 4'hE);
    pressKeys(18'h00002, 4'hE);
    pressKeys(18'h0000F, 4'hE);
    checkOutput("pre_state",  {29'd0, state_code}, ST_SHOW);
    checkOutput("pre_result", result, 32'h12345678);
    checkOutput("pre_flags",  {29'd0, flags}, 32'h1);
    checkOutput("pre_opcode", {28'd0, aluBus.opcode}, 32'hF);
    checkOutput("pre_portB",  aluBus.portB, 32'h00000002);
    RST = 1'b1;
    applyStimulus(18'h0000F, 4'hF, 1);
    checkOutput("midrst_result", result, 32'h0);
    checkOutput("midrst_valid",  {31'd0, result_valid}, 32'h0);
    checkOutput("midrst_state",  {29'd0, state_code}, ST_LOAD_A);
    checkOutput("midrst_portA",  aluBus.portA, 32'h0);
    checkOutput("midrst_opcode", {28'd0, aluBus.opcode}, 32'h0);
    RST = 1'b0;
    applyStimulus(18'h0, 4'hF, 2);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
